slow_memory_param: RTL

//  Parametrised, synthesisable successor of the handshake slow memory model. It

---
 rtl/slow_memory_param_if.sv | 36 +++
 rtl/slow_memory_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/slow_memory_param_if.sv
// -----------------------------------------------------------------------------
// slow_memory_param_if
//   Request/response bus between the L1 miss path (master) and the slow
//   line memory (slave).
//   Request  (master -> slave): mem_read, mem_write, mem_addr, mem_wdata,
//                               mem_wmask
//   Response (slave -> master): mem_rdata, mem_ready, mem_err, mem_busy
//   The clock and reset are plain ports of the modules and are not carried here.
// -----------------------------------------------------------------------------
interface slow_memory_param_if #(
   parameter int ADDR_W = 28,
   parameter int WORD_W = 32,
   parameter int WPL    = 4
);
   localparam int LINE_W = WORD_W * WPL;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic [WPL-1:0]    mem_wmask;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              mem_err;
   logic              mem_busy;

   modport master (
      output mem_read, mem_write, mem_addr, mem_wdata, mem_wmask,
      input  mem_rdata, mem_ready, mem_err, mem_busy
   );

   modport slave (
      input  mem_read, mem_write, mem_addr, mem_wdata, mem_wmask,
      output mem_rdata, mem_ready, mem_err, mem_busy
   );
endinterface

// File: rtl/slow_memory_param.sv
// -----------------------------------------------------------------------------
// slow_memory_param
//   Parametrised slow line memory serving the L1 cache miss path. Full-line
//   reads, word-masked writes, separate read/write latencies and an error
//   response for out-of-range or read+write requests. One request in flight;
//   the request is captured only while idle. All flops update on negedge clk.
//
// Ports
//   clk    in   clock (negedge active)
//   rst_n  in   asynchronous, active-low reset
//   bus    slave modport of slow_memory_param_if:
//            mem_read/mem_write  level requests, sampled only in IDLE
//            mem_addr            line address
//            mem_wdata/mem_wmask write line and per-word enables
//            mem_rdata           read line, non-zero only with mem_ready
//            mem_ready           one-cycle completion pulse
//            mem_err             qualifies mem_ready: request rejected
//            mem_busy            high whenever not IDLE
// -----------------------------------------------------------------------------
module slow_memory_param #(
   parameter int ADDR_W     = 28,
   parameter int WORD_W     = 32,
   parameter int WPL        = 4,
   parameter int MEM_NUM    = 1024,
   parameter int RD_LATENCY = 8,
   parameter int WR_LATENCY = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   slow_memory_param_if.slave  bus
);

   localparam int LINE_W  = WORD_W * WPL;
   localparam int LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
   localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
   localparam int IDX_W   = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;

   // One extra bit so MEM_NUM == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] LP_MEM_NUM = (ADDR_W + 1)'(MEM_NUM);
   localparam logic [CNT_W-1:0] LP_CNT_RD = CNT_W'(RD_LATENCY - 1);
   localparam logic [CNT_W-1:0] LP_CNT_WR = CNT_W'(WR_LATENCY - 1);

   generate
      if (RD_LATENCY < 1) begin : g_bad_rd_lat
         $fatal(1, "slow_memory_param: RD_LATENCY must be >= 1");
      end
      if (WR_LATENCY < 1) begin : g_bad_wr_lat
         $fatal(1, "slow_memory_param: WR_LATENCY must be >= 1");
      end
      if (WPL < 1) begin : g_bad_wpl
         $fatal(1, "slow_memory_param: WPL must be >= 1");
      end
      if (ADDR_W < IDX_W) begin : g_bad_addr_w
         $fatal(1, "slow_memory_param: ADDR_W too narrow for MEM_NUM");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_read;
   logic                r_write;
   logic [ADDR_W-1:0]   r_addr;
   logic [LINE_W-1:0]   r_wdata;
   logic [WPL-1:0]      r_wmask;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_ready;
   logic                r_err;
   logic [LINE_W-1:0]   r_rdata;

   // Storage is deliberately not reset; benches preload it hierarchically.
   logic [LINE_W-1:0]   r_mem [MEM_NUM];

   state_t              w_state_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                w_cap;
   logic                w_ready_nxt;
   logic                w_err_nxt;
   logic [LINE_W-1:0]   w_rdata_nxt;
   logic                w_commit;
   logic                w_oor;
   logic                w_illegal;
   logic [IDX_W-1:0]    w_idx;
   logic [LINE_W-1:0]   w_line;

   assign w_oor     = ({1'b0, r_addr} >= LP_MEM_NUM);
   assign w_illegal = (r_read & r_write) | w_oor;
   assign w_idx     = r_addr[IDX_W-1:0];
   // Index wraps for out-of-range addresses; the line is then discarded.
   assign w_line    = r_mem[w_idx];

   // --------------------------------------------------------------------------
   // Next-state and response decode
   // --------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cap       = 1'b0;
      w_ready_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      w_rdata_nxt = '0;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.mem_read | bus.mem_write) begin
               w_cap       = 1'b1;
               // A read+write request takes the read latency, then errors.
               w_cnt_nxt   = bus.mem_read ? LP_CNT_RD : LP_CNT_WR;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_RESP;
               w_ready_nxt = 1'b1;
               w_err_nxt   = w_illegal;
               if (r_read && !w_illegal) begin
                  w_rdata_nxt = w_line;
               end
               if (r_write && !w_illegal) begin
                  w_commit = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_RESP: begin
            // Outputs fall back to their zero defaults on the way to IDLE.
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State, request capture and registered response
   // --------------------------------------------------------------------------
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= w_ready_nxt;
         r_err   <= w_err_nxt;
         r_rdata <= w_rdata_nxt;
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_read  <= 1'b0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wmask <= '0;
      end else if (w_cap) begin
         r_read  <= bus.mem_read;
         r_write <= bus.mem_write;
         r_addr  <= bus.mem_addr;
         r_wdata <= bus.mem_wdata;
         r_wmask <= bus.mem_wmask;
      end
   end

   // --------------------------------------------------------------------------
   // Array write port: commits on the RESP edge only. A reset mid-WAIT forces
   // IDLE asynchronously, so w_commit can never assert for an aborted write.
   // --------------------------------------------------------------------------
   always_ff @(negedge clk) begin
      if (w_commit) begin
         for (int k = 0; k < WPL; k++) begin
            if (r_wmask[k]) begin
               r_mem[w_idx][k*WORD_W +: WORD_W] <= r_wdata[k*WORD_W +: WORD_W];
            end
         end
      end
   end

   assign bus.mem_rdata = r_rdata;
   assign bus.mem_ready = r_ready;
   assign bus.mem_err   = r_err;
   assign bus.mem_busy  = (r_state != S_IDLE);

endmodule
